// File: rtl/fuzz_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fuzz_stim_sequencer
// Description : Buffers up to DEPTH stimulus vectors from a loader. On start,
//               it replays them onto the fuzz DUT input bus, holding each one
//               for HOLD cycles. It samples dut_y CAP_LAT cycles after each
//               apply and folds each sample into a rotate-XOR signature.
// Option      : FUZZ_SEQ_REPLAY_EN -- keep the buffer after a run and add a
//               'clear' input. When undefined, a run consumes the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzz_stim_sequencer #(
    parameter int VEC_W   = 52,
    parameter int Y_W     = 127,
    parameter int DEPTH   = 32,
    parameter int HOLD    = 1,
    parameter int CAP_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [VEC_W-1:0]         wr_data,
    input  logic                     start,
`ifdef FUZZ_SEQ_REPLAY_EN
    input  logic                     clear,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [VEC_W-1:0]         dut_in,
    input  logic [Y_W-1:0]           dut_y,
    output logic [Y_W-1:0]           sig,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] c_DEPTH   = CW'(DEPTH);
    localparam logic [HW-1:0] c_HOLD_M1 = HW'(HOLD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         r_state, w_state_nx;
    logic [VEC_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_count, r_nleft, r_ncap;
    logic [HW-1:0]      r_hold_cnt;
    logic [CAP_LAT-1:0] r_cap;
    logic [VEC_W-1:0]   r_dut_in;
    logic [Y_W-1:0]     r_sig;
    logic               r_busy, r_done;

    logic               w_idle, w_clear, w_wr, w_start_run, w_start_empty;
    logic               w_step, w_apply, w_apply_any, w_cap, w_finish;
    logic [CW-1:0]      w_n_start;
    logic [VEC_W-1:0]   w_first;

`ifdef FUZZ_SEQ_REPLAY_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    assign w_idle        = (r_state == S_IDLE);
    assign wr_ready      = w_idle && (r_count < c_DEPTH);
    assign w_wr          = wr_valid && wr_ready;
    // A write landing in the start cycle joins the run.
    assign w_n_start     = r_count + CW'(w_wr);
    assign w_start_run   = w_idle && start && !w_clear && (w_n_start != '0);
    assign w_start_empty = w_idle && start && !w_clear && (w_n_start == '0);
    assign w_step        = (r_state == S_RUN) && (r_hold_cnt == c_HOLD_M1);
    assign w_apply       = w_step && (r_nleft != '0);
    assign w_apply_any   = w_start_run || w_apply;
    assign w_cap         = r_cap[CAP_LAT-1];
    assign w_finish      = w_cap && (r_ncap == CW'(1));
    // An empty buffer with a same-cycle write starts from the incoming word.
    assign w_first       = (r_count == '0) ? wr_data : r_mem[r_rptr];

    assign busy   = r_busy;
    assign done   = r_done;
    assign dut_in = r_dut_in;
    assign sig    = r_sig;
    assign count  = r_count;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state logic. The last capture ends the run from RUN or DRAIN.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start_run) w_state_nx = S_RUN;
            S_RUN:   if (w_finish) w_state_nx = S_IDLE;
                     else if (w_step && (r_nleft == '0)) w_state_nx = S_DRAIN;
            S_DRAIN: if (w_finish) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Vector storage. It is not reset because count gates what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wr_data;
    end

    // Capture tag pipeline. Each apply produces one capture CAP_LAT edges later.
    generate
        if (CAP_LAT == 1) begin : g_cap_one
            always_ff @(posedge clk) begin
                if (rst || w_finish) r_cap <= '0;
                else                 r_cap <= w_apply_any;
            end
        end else begin : g_cap_shift
            always_ff @(posedge clk) begin
                if (rst || w_finish) r_cap <= '0;
                else                 r_cap <= {r_cap[CAP_LAT-2:0], w_apply_any};
            end
        end
    endgenerate

    // Buffer bookkeeping, apply sequencing and signature accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_nleft    <= '0;
            r_ncap     <= '0;
            r_hold_cnt <= '0;
            r_dut_in   <= '0;
            r_sig      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_idle) begin
                if (w_clear) begin
                    r_count <= '0;
                    r_wptr  <= '0;
                end else if (w_wr) begin
                    r_count <= r_count + CW'(1);
                    r_wptr  <= r_wptr + AW'(1);
                end
                if (w_start_run) begin
                    r_sig      <= '0;
                    r_dut_in   <= w_first;
                    r_busy     <= 1'b1;
                    r_rptr     <= AW'(1);
                    r_nleft    <= w_n_start - CW'(1);
                    r_ncap     <= w_n_start;
                    r_hold_cnt <= '0;
                end
                if (w_start_empty) begin
                    r_sig  <= '0;
                    r_done <= 1'b1;
                end
            end else begin
                if (w_step) begin
                    r_hold_cnt <= '0;
                    if (r_nleft != '0) begin
                        r_dut_in <= r_mem[r_rptr];
                        r_rptr   <= r_rptr + AW'(1);
                        r_nleft  <= r_nleft - CW'(1);
                    end else begin
                        r_dut_in <= '0;
                    end
                end else if (r_state == S_RUN) begin
                    r_hold_cnt <= r_hold_cnt + HW'(1);
                end
                if (w_cap) begin
                    r_sig  <= {r_sig[Y_W-2:0], r_sig[Y_W-1]} ^ dut_y;
                    r_ncap <= r_ncap - CW'(1);
                end
                if (w_finish) begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_dut_in   <= '0;
                    r_rptr     <= '0;
                    r_hold_cnt <= '0;
`ifndef FUZZ_SEQ_REPLAY_EN
                    r_count    <= '0;
                    r_wptr     <= '0;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fuzz_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fuzz_stim_sequencer
// Description : Self-checking bench for fuzz_stim_sequencer. The DUT model
//               returns the zero-extended stimulus as y. Expected bus values
//               and signatures are queued up front and popped as output
//               appears.
// Option      : FUZZ_SEQ_REPLAY_EN follows the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fuzz_stim_sequencer;

    localparam int VEC_W = 52;
    localparam int Y_W   = 127;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0, wr_ready;
    logic [VEC_W-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [VEC_W-1:0] dut_in;
    logic [Y_W-1:0]   dut_y, sig;
    logic [CW-1:0]    count;

    logic             wr_valid2 = 1'b0, wr_ready2;
    logic [VEC_W-1:0] wr_data2 = '0;
    logic             start2 = 1'b0;
    logic             busy2, done2;
    logic [VEC_W-1:0] dut_in2;
    logic [Y_W-1:0]   dut_y2, sig2;
    logic [CW-1:0]    count2;
`ifdef FUZZ_SEQ_REPLAY_EN
    logic             clear = 1'b0;
    logic             clear2 = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [VEC_W-1:0] loaded[$];
    logic [VEC_W-1:0] exp_dut[$];
    logic [Y_W-1:0]   exp_sig[$];

    assign dut_y  = {{(Y_W-VEC_W){1'b0}}, dut_in};
    assign dut_y2 = {{(Y_W-VEC_W){1'b0}}, dut_in2};

    always #5 clk = ~clk;

    fuzz_stim_sequencer #(.VEC_W(VEC_W), .Y_W(Y_W), .DEPTH(DEPTH), .HOLD(1), .CAP_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .start(start),
`ifdef FUZZ_SEQ_REPLAY_EN
        .clear(clear),
`endif
        .busy(busy), .done(done), .dut_in(dut_in), .dut_y(dut_y), .sig(sig), .count(count)
    );

    fuzz_stim_sequencer #(.VEC_W(VEC_W), .Y_W(Y_W), .DEPTH(DEPTH), .HOLD(3), .CAP_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
        .start(start2),
`ifdef FUZZ_SEQ_REPLAY_EN
        .clear(clear2),
`endif
        .busy(busy2), .done(done2), .dut_in(dut_in2), .dut_y(dut_y2), .sig(sig2), .count(count2)
    );

    function automatic logic [Y_W-1:0] sig_step(input logic [Y_W-1:0] s, input logic [VEC_W-1:0] v);
        return {s[Y_W-2:0], s[Y_W-1]} ^ {{(Y_W-VEC_W){1'b0}}, v};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b0; start = 1'b0; wr_valid2 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        loaded.delete(); exp_dut.delete(); exp_sig.delete();
    endtask

    task automatic load1(input logic [VEC_W-1:0] v);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready got=%b exp=1", wr_ready);
        end
        wr_valid = 1'b1; wr_data = v;
        @(negedge clk);
        wr_valid = 1'b0;
        loaded.push_back(v);
    endtask

    // Start a run on instance 1 and check the bus, busy and done on every
    // cycle until the expected done cycle.
    task automatic run1(input bit with_write, input logic [VEC_W-1:0] wv);
        int n;
        logic [Y_W-1:0] s;
        logic [VEC_W-1:0] e;
        logic [CW-1:0] ecnt;
        if (with_write) begin
            wr_valid = 1'b1; wr_data = wv; loaded.push_back(wv);
        end
        n = loaded.size();
        s = '0;
        foreach (loaded[i]) begin
            exp_dut.push_back(loaded[i]);
            s = sig_step(s, loaded[i]);
        end
        exp_dut.push_back('0);
        exp_sig.push_back(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_valid = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_dut.pop_front();
            checks++;
            if (dut_in !== e) begin
                failures++;
                $display("FAIL run_dut_in k=%0d got=%h exp=%h", k, dut_in, e);
            end
            checks++;
            if (busy !== (k < n)) begin
                failures++;
                $display("FAIL run_busy k=%0d got=%b exp=%b", k, busy, (k < n));
            end
            checks++;
            if (done !== (k == n)) begin
                failures++;
                $display("FAIL run_done k=%0d got=%b exp=%b", k, done, (k == n));
            end
        end
        s = exp_sig.pop_front();
        checks++;
        if (sig !== s) begin
            failures++;
            $display("FAIL run_sig got=%h exp=%h", sig, s);
        end
`ifdef FUZZ_SEQ_REPLAY_EN
        ecnt = CW'(n);
`else
        ecnt = '0;
        loaded.delete();
`endif
        checks++;
        if (count !== ecnt) begin
            failures++;
            $display("FAIL run_count got=%0d exp=%0d", count, ecnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (dut_in !== '0)   begin failures++; $display("FAIL rst_dut_in got=%h exp=0", dut_in); end
        checks++; if (sig !== '0)      begin failures++; $display("FAIL rst_sig got=%h exp=0", sig); end
        checks++; if (count !== '0)    begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (busy2 !== 1'b0 || dut_in2 !== '0 || sig2 !== '0 || count2 !== '0) begin
            failures++; $display("FAIL rst_inst2 got=%b/%h/%h/%0d exp=0/0/0/0", busy2, dut_in2, sig2, count2);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load1(52'd1); load1(52'd2); load1(52'd4);
        checks++;
        if (count !== CW'(3)) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
        run1(1'b0, '0);
    endtask

    task automatic test_repeat();
        do_reset();
        load1(52'd1); load1(52'd1);
        run1(1'b0, '0);
        run1(1'b0, '0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        load1(52'd9);
        run1(1'b1, 52'd3);
        do_reset();
        run1(1'b1, 52'hA_BCDE_F012_3456);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++;
            if (wr_ready !== (i < DEPTH)) begin
                failures++; $display("FAIL full_wr_ready i=%0d got=%b exp=%b", i, wr_ready, (i < DEPTH));
            end
            wr_valid = 1'b1; wr_data = VEC_W'(i * 37 + 100);
            @(negedge clk);
            if (i < DEPTH) loaded.push_back(VEC_W'(i * 37 + 100));
        end
        wr_valid = 1'b0;
        checks++;
        if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
        run1(1'b0, '0);
    endtask

    task automatic test_hold_latency();
        logic [VEC_W-1:0] e;
        logic [Y_W-1:0] s;
        do_reset();
        wr_valid2 = 1'b1; wr_data2 = 52'd5; @(negedge clk);
        wr_data2 = 52'd6; @(negedge clk);
        wr_valid2 = 1'b0;
        repeat (3) exp_dut.push_back(52'd5);
        repeat (2) exp_dut.push_back(52'd6);
        exp_dut.push_back('0);
        exp_sig.push_back(sig_step(sig_step('0, 52'd5), 52'd6));
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            e = exp_dut.pop_front();
            checks++;
            if (dut_in2 !== e) begin failures++; $display("FAIL hold_dut_in k=%0d got=%h exp=%h", k, dut_in2, e); end
            checks++;
            if (done2 !== (k == 5)) begin failures++; $display("FAIL hold_done k=%0d got=%b exp=%b", k, done2, (k == 5)); end
            checks++;
            if (busy2 !== (k < 5)) begin failures++; $display("FAIL hold_busy k=%0d got=%b exp=%b", k, busy2, (k < 5)); end
            if (k >= 2 && k < 5) begin
                checks++;
                if (sig2 !== Y_W'(5)) begin failures++; $display("FAIL hold_sig_mid k=%0d got=%h exp=5", k, sig2); end
            end
        end
        s = exp_sig.pop_front();
        checks++;
        if (sig2 !== s) begin failures++; $display("FAIL hold_sig got=%h exp=%h", sig2, s); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        load1(52'd1); load1(52'd2); load1(52'd4); load1(52'd8);
        start = 1'b1; @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_in !== 52'd2 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_pre got=%h/%b exp=2/1", dut_in, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_in !== '0 || sig !== '0 || count !== '0) begin
            failures++;
            $display("FAIL mid_rst got=%b/%b/%h/%h/%0d exp=0/0/0/0/0", busy, done, dut_in, sig, count);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (sig !== '0 || done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL mid_quiet k=%0d got=%h/%b/%b exp=0/0/0", k, sig, done, busy);
            end
        end
        loaded.delete();
    endtask

`ifdef FUZZ_SEQ_REPLAY_EN
    task automatic test_replay();
        do_reset();
        load1(52'd1); load1(52'd2); load1(52'd4);
        run1(1'b0, '0);
        run1(1'b0, '0);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        checks++;
        if (count !== '0) begin failures++; $display("FAIL replay_clear got=%0d exp=0", count); end
        loaded.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_back_to_back();
        test_full();
        test_hold_latency();
        test_reset_midrun();
`ifdef FUZZ_SEQ_REPLAY_EN
        test_replay();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
